// File: rtl/disp_scan_if.sv
// Bundle of the signals between the time/set-mode logic and the display
// scan controller. The master side supplies digits and control; the
// slave side (the scan controller) drives the decoder code and the
// digit enables.
interface disp_scan_if;
  logic       en;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic [3:0] d5;
  logic [5:0] blink_mask;
  logic       lz_en;
  logic [3:0] bcd;
  logic [5:0] an;
  logic       frame_start;

  modport master (
    output en, d0, d1, d2, d3, d4, d5, blink_mask, lz_en,
    input  bcd, an, frame_start
  );

  modport slave (
    input  en, d0, d1, d2, d3, d4, d5, blink_mask, lz_en,
    output bcd, an, frame_start
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a six-digit 7-segment display.
// Each digit slot is a DEAD gap (all enables off, decoder code already
// presented) followed by an ON window with one active-low enable.
// Digits and blink mask are captured once per frame so a frame never
// shows a mix of old and new values.
module disp_scan_ctrl #(
  parameter int ON_CYC       = 1000,
  parameter int DEAD_CYC     = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  disp_scan_if.slave dsp
);

  localparam int SLOT_MAX = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int CW       = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int FW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [FW-1:0] FR_LAST   = FW'(BLINK_FRAMES - 1);
  localparam logic [5:0]    AN_OFF    = 6'b111111;

  typedef enum logic [1:0] {
    S_OFF,
    S_DEAD,
    S_ON
  } state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   frm_cnt;
  logic            blink_phase;
  logic [5:0][3:0] snap;
  logic [5:0]      snap_mask;
  logic [5:0][3:0] d_live;
  logic [2:0]      idx_nxt;
  logic            last_slot;
  logic            slot_dark;

  // A slot stays dark when its digit is in the hidden blink half, is a
  // suppressed leading hour zero, or carries a non-BCD code.
  function automatic logic slot_blank(input logic [2:0] i,
                                      input logic [3:0] code,
                                      input logic       msk,
                                      input logic       phase,
                                      input logic       lz);
    return (msk & phase) | (lz & (i == 3'd5) & (code == 4'd0)) | (code > 4'd9);
  endfunction

  assign d_live    = {dsp.d5, dsp.d4, dsp.d3, dsp.d2, dsp.d1, dsp.d0};
  assign last_slot = (idx == 3'd5);
  assign idx_nxt   = last_slot ? 3'd0 : idx + 3'd1;
  assign slot_dark = slot_blank(idx, snap[idx], snap_mask[idx], blink_phase, dsp.lz_en);

  // Scan sequencer: slot timing, frame snapshot, blink phase and all
  // display-side outputs, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_OFF;
      idx             <= 3'd0;
      cnt             <= '0;
      frm_cnt         <= '0;
      blink_phase     <= 1'b0;
      snap            <= '0;
      snap_mask       <= '0;
      dsp.an          <= AN_OFF;
      dsp.bcd         <= 4'd0;
      dsp.frame_start <= 1'b0;
    end else begin
      dsp.frame_start <= 1'b0;
      case (state)
        S_OFF: begin
          dsp.an <= AN_OFF;
          if (dsp.en) begin
            state           <= S_DEAD;
            idx             <= 3'd0;
            cnt             <= '0;
            snap            <= d_live;
            snap_mask       <= dsp.blink_mask;
            dsp.bcd         <= dsp.d0;
            dsp.frame_start <= 1'b1;
          end
        end

        S_DEAD: begin
          if (!dsp.en) begin
            state  <= S_OFF;
            dsp.an <= AN_OFF;
            idx    <= 3'd0;
            cnt    <= '0;
          end else if (cnt == DEAD_LAST) begin
            state  <= S_ON;
            cnt    <= '0;
            dsp.an <= slot_dark ? AN_OFF : ~(6'b000001 << idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_ON: begin
          if (!dsp.en) begin
            state  <= S_OFF;
            dsp.an <= AN_OFF;
            idx    <= 3'd0;
            cnt    <= '0;
          end else if (cnt == ON_LAST) begin
            state  <= S_DEAD;
            cnt    <= '0;
            idx    <= idx_nxt;
            dsp.an <= AN_OFF;
            if (last_slot) begin
              // Frame boundary: fresh snapshot, pulse, blink bookkeeping.
              snap            <= d_live;
              snap_mask       <= dsp.blink_mask;
              dsp.bcd         <= dsp.d0;
              dsp.frame_start <= 1'b1;
              if (frm_cnt == FR_LAST) begin
                frm_cnt     <= '0;
                blink_phase <= ~blink_phase;
              end else begin
                frm_cnt <= frm_cnt + 1'b1;
              end
            end else begin
              dsp.bcd <= snap[idx_nxt];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= S_OFF;
          dsp.an <= AN_OFF;
          idx    <= 3'd0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed table of scan-timing points, hand
// sequences for reset, blink, coherency, invalid code and enable drop,
// then randomized stimulus against a frame-arithmetic reference model.
module tb_disp_scan_ctrl;

  localparam int ON    = 4;
  localparam int DEAD  = 2;
  localparam int BLINK = 2;
  localparam int SLOT  = ON + DEAD;
  localparam int FRAME = 6 * SLOT;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  disp_scan_if ifc ();

  disp_scan_ctrl #(
    .ON_CYC      (ON),
    .DEAD_CYC    (DEAD),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dsp  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: time since scan start, completed frames,
  // per-frame snapshot and last decoder code.
  bit         m_run;
  int         m_t;
  int         m_frames;
  int         m_snap [6];
  logic [5:0] m_mask;
  logic       m_blank;
  logic [5:0] m_an;
  logic [3:0] m_bcd;
  logic       m_fs;

  typedef struct {
    logic       lz;
    logic [3:0] d5v;
    int         p;
    logic [5:0] an;
    logic [3:0] bcd;
    logic       fs;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 0;
    m_t      = 0;
    m_frames = 0;
    for (int i = 0; i < 6; i++) m_snap[i] = 0;
    m_mask  = '0;
    m_blank = 1'b0;
    m_an    = 6'h3F;
    m_bcd   = 4'd0;
    m_fs    = 1'b0;
  endtask

  task automatic take_snap();
    m_snap[0] = int'(ifc.d0);
    m_snap[1] = int'(ifc.d1);
    m_snap[2] = int'(ifc.d2);
    m_snap[3] = int'(ifc.d3);
    m_snap[4] = int'(ifc.d4);
    m_snap[5] = int'(ifc.d5);
    m_mask    = ifc.blink_mask;
  endtask

  // Called at each rising edge with the inputs present at that edge.
  task automatic model_step();
    int  p;
    int  slot;
    int  w;
    bit  hidden;
    m_fs = 1'b0;
    if (!m_run) begin
      m_an = 6'h3F;
      if (ifc.en) begin
        m_run = 1;
        m_t   = 0;
        take_snap();
        m_fs  = 1'b1;
        m_bcd = 4'(m_snap[0]);
      end
    end else if (!ifc.en) begin
      m_run = 0;
      m_an  = 6'h3F;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_frames++;
        take_snap();
        m_fs = 1'b1;
      end
      p     = m_t % FRAME;
      slot  = p / SLOT;
      w     = p % SLOT;
      m_bcd = 4'(m_snap[slot]);
      if (w < DEAD) begin
        m_an = 6'h3F;
      end else begin
        if (w == DEAD) begin
          hidden  = ((m_frames / BLINK) % 2) == 1;
          m_blank = (m_mask[slot] && hidden) ||
                    (ifc.lz_en && slot == 5 && m_snap[5] == 0) ||
                    (m_snap[slot] > 9);
        end
        m_an = m_blank ? 6'h3F : ~(6'b000001 << slot);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_an", 32'(ifc.an), 32'(m_an));
    check("model_bcd", 32'(ifc.bcd), 32'(m_bcd));
    check("model_frame_start", 32'(ifc.frame_start), 32'(m_fs));
    check("an_at_most_one_low", 32'($countones(~ifc.an) <= 1), 32'd1);
  endtask

  task automatic set_digits(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] a3, input logic [3:0] a4, input logic [3:0] a5);
    ifc.d0 = a0;
    ifc.d1 = a1;
    ifc.d2 = a2;
    ifc.d3 = a3;
    ifc.d4 = a4;
    ifc.d5 = a5;
  endtask

  // Leaves the bench at the first cycle of a fresh scan (frame position 0).
  task automatic start_scan();
    ifc.en = 1'b0;
    tick();
    tick();
    ifc.en = 1'b1;
    tick();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_an", 32'(ifc.an), 32'h3F);
    check("rst_async_bcd", 32'(ifc.bcd), 32'h0);
    check("rst_async_fs", 32'(ifc.frame_start), 32'h0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    ifc.en         = 1'b0;
    ifc.blink_mask = '0;
    ifc.lz_en      = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();

    // Scan-timing points with digits 1,2,3,4,5,d5v.
    tbl[0]  = '{1'b0, 4'd0, 0,  6'b111111, 4'd1, 1'b1};
    tbl[1]  = '{1'b0, 4'd0, 1,  6'b111111, 4'd1, 1'b0};
    tbl[2]  = '{1'b0, 4'd0, 2,  6'b111110, 4'd1, 1'b0};
    tbl[3]  = '{1'b0, 4'd0, 5,  6'b111110, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, 4'd0, 6,  6'b111111, 4'd2, 1'b0};
    tbl[5]  = '{1'b0, 4'd0, 8,  6'b111101, 4'd2, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 20, 6'b110111, 4'd4, 1'b0};
    tbl[7]  = '{1'b0, 4'd0, 26, 6'b101111, 4'd5, 1'b0};
    tbl[8]  = '{1'b0, 4'd0, 32, 6'b011111, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'd0, 35, 6'b011111, 4'd0, 1'b0};
    tbl[10] = '{1'b0, 4'd0, 36, 6'b111111, 4'd1, 1'b1};
    tbl[11] = '{1'b1, 4'd0, 32, 6'b111111, 4'd0, 1'b0};
    tbl[12] = '{1'b1, 4'd1, 33, 6'b011111, 4'd1, 1'b0};

    #12;
    rst_n = 1'b1;
    tick();
    check("reset_an", 32'(ifc.an), 32'h3F);
    check("reset_bcd", 32'(ifc.bcd), 32'h0);
    check("reset_fs", 32'(ifc.frame_start), 32'h0);

    for (int i = 0; i < 13; i++) begin
      set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, tbl[i].d5v);
      ifc.lz_en = tbl[i].lz;
      start_scan();
      repeat (tbl[i].p) tick();
      check($sformatf("tbl%0d_an", i), 32'(ifc.an), 32'(tbl[i].an));
      check($sformatf("tbl%0d_bcd", i), 32'(ifc.bcd), 32'(tbl[i].bcd));
      check($sformatf("tbl%0d_fs", i), 32'(ifc.frame_start), 32'(tbl[i].fs));
    end

    // Asynchronous reset in the middle of an ON window, released with en low.
    ifc.lz_en = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0);
    start_scan();
    repeat (2) tick();
    check("pre_rst_an", 32'(ifc.an), 32'h3E);
    ifc.en = 1'b0;
    async_reset();
    repeat (3) tick();
    check("post_rst_off_an", 32'(ifc.an), 32'h3F);
    check("post_rst_off_fs", 32'(ifc.frame_start), 32'h0);

    // Blink with fresh frame counter: digits 0,1 visible frames 0-1, hidden 2-3.
    ifc.blink_mask = 6'b000011;
    start_scan();
    for (int t = 0; t < 4 * FRAME; t++) begin
      int p;
      int f;
      if (t > 0) tick();
      p = t % FRAME;
      f = t / FRAME;
      if (p == 2)
        check($sformatf("blink_f%0d_d0", f), 32'(ifc.an), (f < 2) ? 32'h3E : 32'h3F);
      if (p == 8)
        check($sformatf("blink_f%0d_d1", f), 32'(ifc.an), (f < 2) ? 32'h3D : 32'h3F);
      if (p == 14)
        check($sformatf("blink_f%0d_d2", f), 32'(ifc.an), 32'h3B);
    end
    ifc.blink_mask = '0;

    // Snapshot coherency, then leading-zero release on the following frame.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0);
    start_scan();
    repeat (7) tick();
    ifc.d3 = 4'd7;
    repeat (13) tick();
    check("coh_old_bcd", 32'(ifc.bcd), 32'd4);
    check("coh_old_an", 32'(ifc.an), 32'h37);
    repeat (FRAME) tick();
    check("coh_new_bcd", 32'(ifc.bcd), 32'd7);
    ifc.lz_en = 1'b1;
    repeat (12) tick();
    check("lz_blank_an", 32'(ifc.an), 32'h3F);
    ifc.d5 = 4'd1;
    repeat (FRAME) tick();
    check("lz_shown_an", 32'(ifc.an), 32'h1F);
    check("lz_shown_bcd", 32'(ifc.bcd), 32'd1);
    ifc.lz_en = 1'b0;

    // Non-BCD code keeps its digit dark but still reaches the decoder.
    set_digits(4'd1, 4'd2, 4'hC, 4'd4, 4'd5, 4'd0);
    start_scan();
    repeat (14) tick();
    check("invalid_an", 32'(ifc.an), 32'h3F);
    check("invalid_bcd", 32'(ifc.bcd), 32'hC);

    // Enable drop in the third ON cycle of digit 2, restart, drop at wrap.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0);
    start_scan();
    repeat (16) tick();
    check("drop_pre_an", 32'(ifc.an), 32'h3B);
    ifc.en = 1'b0;
    tick();
    check("drop_an", 32'(ifc.an), 32'h3F);
    check("drop_bcd_hold", 32'(ifc.bcd), 32'd3);
    repeat (2) tick();
    check("drop_stay_an", 32'(ifc.an), 32'h3F);
    ifc.en = 1'b1;
    tick();
    check("restart_fs", 32'(ifc.frame_start), 32'h1);
    check("restart_bcd", 32'(ifc.bcd), 32'd1);
    repeat (FRAME - 1) tick();
    ifc.en = 1'b0;
    tick();
    check("wrap_drop_fs", 32'(ifc.frame_start), 32'h0);
    check("wrap_drop_an", 32'(ifc.an), 32'h3F);
    check("wrap_drop_bcd", 32'(ifc.bcd), 32'd0);

    // Randomized stimulus against the reference model.
    ifc.en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int         k;
      logic [3:0] v;
      tick();
      if ($urandom_range(0, 19) == 0) begin
        k = int'($urandom_range(0, 5));
        v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        case (k)
          0: ifc.d0 = v;
          1: ifc.d1 = v;
          2: ifc.d2 = v;
          3: ifc.d3 = v;
          4: ifc.d4 = v;
          default: ifc.d5 = v;
        endcase
      end
      if ($urandom_range(0, 149) == 0) ifc.blink_mask = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 99) == 0) ifc.lz_en = ~ifc.lz_en;
      if (ifc.en && $urandom_range(0, 299) == 0) ifc.en = 1'b0;
      else if (!ifc.en && $urandom_range(0, 5) == 0) ifc.en = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
